ram_lane_banked: RTL

- Parametrised single-port RAM.
- Word width is built by stacking LANES identical lane slices that share the same address, one slice per byte-lane, so width is no longer fixed at two slices.
- Adds per-lane write enables, a registered read with a valid strobe, and a hardware clear-sweep that zeroes every location after reset.
- Sits where fixed 4x16 RAMs were used; it is the general memory primitive for register files and scratch buffers.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_lane.sv | 38 +++
 rtl/ram_lane_banked.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the banked single-port RAM:
//   stateT  - controller states (INIT clear-sweep, IDLE serving requests)
//   laneLsb - bit offset of a lane slice inside the full data word
// ---------------------------------------------------------------------------
package ram_pkg;

  // INIT zeroes the array one word per cycle; IDLE serves requests.
  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } stateT;

  // Lane k occupies bits [k*laneW +: laneW] of the data word.
  function automatic int laneLsb(input int lane, input int laneW);
    return lane * laneW;
  endfunction

endpackage

// File: rtl/ram_lane.sv
// ---------------------------------------------------------------------------
// ram_lane
// One LANE_W x 2**ADDR_W storage slice. The write is synchronous. The read
// is combinational here because the parent registers the whole word once,
// which keeps every lane aligned to a single read latency.
// Ports:
//   clk  - rising-edge clock
//   we   - write enable for this lane
//   addr - word address (already muxed between sweep pointer and request)
//   din  - lane write data
//   dout - lane contents at addr
// ---------------------------------------------------------------------------
module ram_lane #(
  parameter int ADDR_W = 2,
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANE_W-1:0] din,
  output logic [LANE_W-1:0] dout
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [LANE_W-1:0] r_mem [DEPTH];

  // The array has no reset; the parent's clear-sweep zeroes it through the
  // normal write path, so this maps onto plain RAM macros or LUT RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end
  end

  assign dout = r_mem[addr];

endmodule

// File: rtl/ram_lane_banked.sv
// ---------------------------------------------------------------------------
// ram_lane_banked
// Parametrised single-port RAM built from LANES byte-lane slices that share
// one address. It has per-lane write enables and a registered read with a
// one-cycle valid pulse. After every reset, a clear-sweep writes zero to
// each word before the first request is accepted.
// Ports:
//   clk      - rising-edge clock
//   clr      - asynchronous active-high reset
//   req      - request strobe, taken when ready is high
//   rw       - 1 = write, 0 = read
//   addr     - word address
//   be       - per-lane write enable (writes only)
//   data_in  - write data, lane k at [k*LANE_W +: LANE_W]
//   data_out - registered read data, holds between reads
//   valid    - pulses the cycle after an accepted read
//   ready    - request is accepted this cycle
//   busy     - clear-sweep in progress
// ---------------------------------------------------------------------------
module ram_lane_banked
  import ram_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int LANES  = 2,
  parameter int LANE_W = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     req,
  input  logic                     rw,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [LANES-1:0]         be,
  input  logic [LANES*LANE_W-1:0]  data_in,
  output logic [LANES*LANE_W-1:0]  data_out,
  output logic                     valid,
  output logic                     ready,
  output logic                     busy
);

  localparam int DATA_W = LANES * LANE_W;

  stateT             r_state;
  stateT             w_nextState;
  logic [ADDR_W-1:0] r_sweepPtr;
  logic [DATA_W-1:0] r_dataOut;
  logic [DATA_W-1:0] w_rdWord;
  logic              r_valid;
  logic              w_ready;
  logic              w_busy;
  logic              w_accept;
  logic              w_wrAccept;
  logic              w_rdAccept;
  logic              w_sweeping;

  // Next-state and status decode. The sweep leaves INIT on the cycle the
  // pointer reaches the last word (all ones); that final zero write still
  // happens because the lane write enables depend only on r_state.
  always_comb begin
    w_nextState = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      INIT: begin
        w_busy = 1'b1;
        if (r_sweepPtr == '1) begin
          w_nextState = IDLE;
        end
      end
      IDLE: begin
        w_ready = 1'b1;
      end
      default: begin
        w_nextState = INIT;
      end
    endcase
  end

  assign w_sweeping = (r_state == INIT);
  assign w_accept   = req & w_ready;
  assign w_wrAccept = w_accept & rw;
  assign w_rdAccept = w_accept & ~rw;

  // State register and sweep pointer. The pointer restarts from zero on
  // every reset, so a sweep cut short by reset always runs in full.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= INIT;
      r_sweepPtr <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_sweeping) begin
        r_sweepPtr <= r_sweepPtr + 1'b1;
      end
    end
  end

  // Read register. valid tracks accepted reads cycle by cycle, so it stays
  // high through back-to-back reads. data_out changes only on a read.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_dataOut <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_rdAccept;
      if (w_rdAccept) begin
        r_dataOut <= w_rdWord;
      end
    end
  end

  // One slice per lane. During the sweep, every lane writes zero at the
  // pointer. Otherwise each lane takes the request address and writes only
  // when its byte enable is set on an accepted write.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int LSB = laneLsb(k, LANE_W);

    logic              w_laneWe;
    logic [ADDR_W-1:0] w_laneAddr;
    logic [LANE_W-1:0] w_laneDin;

    assign w_laneWe   = w_sweeping | (w_wrAccept & be[k]);
    assign w_laneAddr = w_sweeping ? r_sweepPtr : addr;
    assign w_laneDin  = w_sweeping ? '0 : data_in[LSB +: LANE_W];

    ram_lane #(
      .ADDR_W (ADDR_W),
      .LANE_W (LANE_W)
    ) u_lane (
      .clk  (clk),
      .we   (w_laneWe),
      .addr (w_laneAddr),
      .din  (w_laneDin),
      .dout (w_rdWord[LSB +: LANE_W])
    );
  end

  assign data_out = r_dataOut;
  assign valid    = r_valid;
  assign ready    = w_ready;
  assign busy     = w_busy;

endmodule
